img_edge_detector_top: RTL and testbench

Top level of the image edge detector. It holds a 5×5 8-bit greyscale input frame buffer and a matching output frame buffer. On `run`, it applies a 3×3 Sobel edge kernel to every input pixel and writes the gradient magnitudes to the output buffer. It then raises `done`. Hosts load the input frame and read back the result through the two buffer ports.

---
 rtl/img_edge_pkg.sv | 17 +
 rtl/img_edge_detector_frame_buf.sv | 47 ++++
 rtl/img_edge_detector_top.sv | 165 ++++++++++++++++
 tb/tb_img_edge_detector_top.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_edge_pkg.sv
// Shared constants and FSM state type for the image edge detector.
package img_edge_pkg;

    localparam int unsigned IMG_W   = 5;
    localparam int unsigned IMG_H   = 5;
    localparam int unsigned PXL_W   = 8;
    localparam int unsigned X_W     = $clog2(IMG_W);
    localparam int unsigned Y_W     = $clog2(IMG_H);
    localparam int unsigned MAG_MAX = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/img_edge_detector_frame_buf.sv
// Frame buffer: un-reset pixel storage with one write port, one registered
// read port, and the whole array exposed combinationally.
module frame_buf #(
    parameter int unsigned W  = 5,
    parameter int unsigned H  = 5,
    parameter int unsigned PW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [$clog2(W)-1:0]   wr_x,
    input  logic [$clog2(H)-1:0]   wr_y,
    input  logic [PW-1:0]          wr_data,
    input  logic                   rd_en,
    input  logic [$clog2(W)-1:0]   rd_x,
    input  logic [$clog2(H)-1:0]   rd_y,
    output logic [PW-1:0]          rd_data,
    output logic [PW-1:0]          img [H][W]
);

    logic [PW-1:0] img_buf [H][W];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = (32'(wr_x) < W) && (32'(wr_y) < H);
    assign rd_in_range = (32'(rd_x) < W) && (32'(rd_y) < H);

    assign img = img_buf;

    // Storage write; deliberately no reset so a loaded image survives rst.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            img_buf[wr_y][wr_x] <= wr_data;
        end
    end

    // Registered read; holds while rd_en is low, out-of-range reads give 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? img_buf[rd_y][rd_x] : '0;
        end
    end

endmodule

// File: rtl/img_edge_detector_top.sv
// Sobel edge detector over a small greyscale frame held in on-chip buffers.
module img_edge_detector_top
    import img_edge_pkg::*;
#(
    parameter int unsigned IMG_W = img_edge_pkg::IMG_W,
    parameter int unsigned IMG_H = img_edge_pkg::IMG_H,
    parameter int unsigned PXL_W = img_edge_pkg::PXL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic                       done,
    input  logic                       frame_buf_in_wr_en,
    input  logic [$clog2(IMG_W)-1:0]   frame_buf_in_wr_x,
    input  logic [$clog2(IMG_H)-1:0]   frame_buf_in_wr_y,
    input  logic [PXL_W-1:0]           frame_buf_in_wr_data_pxl,
    input  logic                       frame_buf_out_rd_en,
    input  logic [$clog2(IMG_W)-1:0]   frame_buf_out_rd_x,
    input  logic [$clog2(IMG_H)-1:0]   frame_buf_out_rd_y,
    output logic [PXL_W-1:0]           frame_buf_out_rd_data_pxl
);

    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);
    localparam int unsigned SUM_W = PXL_W + 2;
    localparam int unsigned DIF_W = PXL_W + 3;

    state_t state, state_nxt;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          last_pxl;

    logic [PXL_W-1:0] in_img [IMG_H][IMG_W];
    logic [PXL_W-1:0] unused_out_img [IMG_H][IMG_W];
    logic [PXL_W-1:0] unused_in_rd_data;

    logic                     in_wr_en;
    logic                     out_wr_en;
    logic [PXL_W-1:0]         out_wr_data;

    logic [YW-1:0]            yu, yd;
    logic [XW-1:0]            xl, xr;
    logic [SUM_W-1:0]         sum_r, sum_l, sum_d, sum_u;
    logic signed [DIF_W-1:0]  gx, gy;
    logic [SUM_W-1:0]         ax, ay;
    logic [DIF_W-1:0]         mag;
    logic [PXL_W-1:0]         pix;
    logic                     interior;

    assign last_pxl  = (x_cnt == XW'(IMG_W - 1)) && (y_cnt == YW'(IMG_H - 1));
    assign in_wr_en  = frame_buf_in_wr_en && (state != PROC);
    assign out_wr_en = (state == PROC);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> PROC on run, PROC -> DONE after the last pixel,
    // DONE -> IDLE once run is released.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run)      state_nxt = PROC;
            PROC:    if (last_pxl) state_nxt = DONE;
            DONE:    if (!run)     state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Raster counters, x fastest; held at (0,0) outside PROC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (state != PROC) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == XW'(IMG_W - 1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + YW'(1);
        end else begin
            x_cnt <= x_cnt + XW'(1);
        end
    end

    // done is registered one cycle behind entering DONE and drops with run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == DONE) && run;
        end
    end

    // Sobel kernel over the 3x3 window; neighbour indices are clamped at the
    // border so the lookup stays in range, the result is then forced to 0 there.
    always_comb begin
        yu = (y_cnt == '0) ? y_cnt : y_cnt - YW'(1);
        yd = (y_cnt == YW'(IMG_H - 1)) ? y_cnt : y_cnt + YW'(1);
        xl = (x_cnt == '0) ? x_cnt : x_cnt - XW'(1);
        xr = (x_cnt == XW'(IMG_W - 1)) ? x_cnt : x_cnt + XW'(1);

        sum_r = SUM_W'(in_img[yu][xr]) + {1'b0, in_img[y_cnt][xr], 1'b0} + SUM_W'(in_img[yd][xr]);
        sum_l = SUM_W'(in_img[yu][xl]) + {1'b0, in_img[y_cnt][xl], 1'b0} + SUM_W'(in_img[yd][xl]);
        sum_d = SUM_W'(in_img[yd][xl]) + {1'b0, in_img[yd][x_cnt], 1'b0} + SUM_W'(in_img[yd][xr]);
        sum_u = SUM_W'(in_img[yu][xl]) + {1'b0, in_img[yu][x_cnt], 1'b0} + SUM_W'(in_img[yu][xr]);

        gx = DIF_W'(sum_r) - DIF_W'(sum_l);
        gy = DIF_W'(sum_d) - DIF_W'(sum_u);

        ax = gx[DIF_W-1] ? SUM_W'(-gx) : SUM_W'(gx);
        ay = gy[DIF_W-1] ? SUM_W'(-gy) : SUM_W'(gy);

        mag = DIF_W'(ax) + DIF_W'(ay);
        pix = (mag > DIF_W'(MAG_MAX)) ? PXL_W'(MAG_MAX) : mag[PXL_W-1:0];

        interior = (x_cnt != '0) && (x_cnt != XW'(IMG_W - 1)) &&
                   (y_cnt != '0) && (y_cnt != YW'(IMG_H - 1));

        out_wr_data = interior ? pix : '0;
    end

    frame_buf #(
        .W  (IMG_W),
        .H  (IMG_H),
        .PW (PXL_W)
    ) frame_buf_in (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_wr_en),
        .wr_x    (frame_buf_in_wr_x),
        .wr_y    (frame_buf_in_wr_y),
        .wr_data (frame_buf_in_wr_data_pxl),
        .rd_en   (1'b0),
        .rd_x    ('0),
        .rd_y    ('0),
        .rd_data (unused_in_rd_data),
        .img     (in_img)
    );

    frame_buf #(
        .W  (IMG_W),
        .H  (IMG_H),
        .PW (PXL_W)
    ) frame_buf_out (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (out_wr_en),
        .wr_x    (x_cnt),
        .wr_y    (y_cnt),
        .wr_data (out_wr_data),
        .rd_en   (frame_buf_out_rd_en),
        .rd_x    (frame_buf_out_rd_x),
        .rd_y    (frame_buf_out_rd_y),
        .rd_data (frame_buf_out_rd_data_pxl),
        .img     (unused_out_img)
    );

endmodule

// File: tb/tb_img_edge_detector_top.sv
// Self-checking bench for img_edge_detector_top: table vectors plus a read scoreboard.
module tb_img_edge_detector_top;
    import img_edge_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       done;
    logic       wr_en;
    logic [2:0] wr_x, wr_y;
    logic [7:0] wr_d;
    logic       rd_en;
    logic [2:0] rd_x, rd_y;
    logic [7:0] rd_d;

    int errors = 0;
    int checks = 0;

    logic [7:0] img [5][5];

    typedef struct {
        int         y;
        int         x;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    vec_t diag_vecs [16];
    sb_t  sb_q [$];

    img_edge_detector_top #(
        .IMG_W (5),
        .IMG_H (5),
        .PXL_W (8)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .run                       (run),
        .done                      (done),
        .frame_buf_in_wr_en        (wr_en),
        .frame_buf_in_wr_x         (wr_x),
        .frame_buf_in_wr_y         (wr_y),
        .frame_buf_in_wr_data_pxl  (wr_d),
        .frame_buf_out_rd_en       (rd_en),
        .frame_buf_out_rd_x        (rd_x),
        .frame_buf_out_rd_y        (rd_y),
        .frame_buf_out_rd_data_pxl (rd_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(int y, int x);
        int sr, sl, sd, su, gx, gy, m;
        if (x == 0 || y == 0 || x == 4 || y == 4) return 0;
        sr = img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1];
        sl = img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1];
        sd = img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1];
        su = img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1];
        gx = sr - sl;
        gy = sd - su;
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        return (m > 255) ? 255 : m;
    endfunction

    task automatic load_img();
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                @(negedge clk);
                wr_en = 1'b1;
                wr_x  = 3'(x);
                wr_y  = 3'(y);
                wr_d  = img[y][x];
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns at the posedge that samples run (edge N).
    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
    endtask

    // Waits for done with a bound; i counts edges after edge N.
    task automatic wait_done(input int start_i, input bit chk_lat);
        int lat;
        lat = -1;
        for (int i = start_i + 1; i <= 150; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("done_rise", done, 1);
        if (chk_lat) check("done_latency", lat, 26);
    endtask

    task automatic drop_run();
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("done_fall", done, 0);
    endtask

    // Pipelined reads: expectation pushed when the read is driven, popped and
    // compared one cycle later when the data is registered.
    task automatic read_frame(input string tag);
        sb_t e;
        for (int k = 0; k < 27; k++) begin
            int y, x;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, rd_d, e.exp);
            end
            if (k < 25) begin
                y = k / 5;
                x = k % 5;
            end else begin
                y = (k == 25) ? 5 : 0;
                x = (k == 25) ? 0 : 6;
            end
            rd_en = 1'b1;
            rd_x  = 3'(x);
            rd_y  = 3'(y);
            sb_q.push_back('{$sformatf("%s(%0d,%0d)", tag, y, x),
                             (k < 25) ? 8'(model(y, x)) : 8'd0});
        end
        @(negedge clk);
        e = sb_q.pop_front();
        check(e.name, rd_d, e.exp);
        rd_en = 1'b0;
    endtask

    task automatic read_vecs();
        sb_t e;
        foreach (diag_vecs[i]) begin
            @(negedge clk);
            rd_en = 1'b1;
            rd_x  = 3'(diag_vecs[i].x);
            rd_y  = 3'(diag_vecs[i].y);
            sb_q.push_back('{$sformatf("diag_vec(%0d,%0d)", diag_vecs[i].y, diag_vecs[i].x),
                             diag_vecs[i].exp});
            @(negedge clk);
            rd_en = 1'b0;
            e = sb_q.pop_front();
            check(e.name, rd_d, e.exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        diag_vecs[0]  = '{1, 1, 8'd4};
        diag_vecs[1]  = '{1, 2, 8'd255};
        diag_vecs[2]  = '{2, 1, 8'd255};
        diag_vecs[3]  = '{2, 2, 8'd4};
        diag_vecs[4]  = '{3, 3, 8'd4};
        diag_vecs[5]  = '{1, 3, 8'd255};
        diag_vecs[6]  = '{3, 1, 8'd255};
        diag_vecs[7]  = '{2, 3, 8'd255};
        diag_vecs[8]  = '{0, 0, 8'd0};
        diag_vecs[9]  = '{4, 4, 8'd0};
        diag_vecs[10] = '{0, 2, 8'd0};
        diag_vecs[11] = '{2, 4, 8'd0};
        diag_vecs[12] = '{4, 1, 8'd0};
        diag_vecs[13] = '{2, 0, 8'd0};
        diag_vecs[14] = '{5, 1, 8'd0};
        diag_vecs[15] = '{1, 7, 8'd0};

        rst = 1'b1; run = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_x = '0; wr_y = '0; wr_d = '0; rd_x = '0; rd_y = '0;
        repeat (2) @(negedge clk);
        check("reset_done", done, 0);
        check("reset_rd_data", rd_d, 0);
        rst = 1'b0;

        // Diagonal image, loaded then survives a reset pulse.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img[y][x] = (x == y) ? 8'(250 + y) : 8'd0;
        load_img();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                check($sformatf("survive(%0d,%0d)", y, x), dut.frame_buf_in.img_buf[y][x], img[y][x]);
        start_run();
        wait_done(0, 1'b1);
        read_vecs();

        // Read data holds while rd_en is low.
        @(negedge clk); rd_en = 1'b1; rd_x = 3'd2; rd_y = 3'd1;
        @(negedge clk); rd_en = 1'b0; rd_x = 3'd0; rd_y = 3'd0;
        repeat (3) @(negedge clk);
        check("rd_hold", rd_d, 255);

        // done held and no re-run while run stays high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("done_held", done, 1);
        end
        check("state_done", dut.state, DONE);
        drop_run();

        // Re-run gives identical results.
        start_run();
        wait_done(0, 1'b1);
        read_frame("rerun");
        drop_run();

        // Flat image.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img[y][x] = 8'd100;
        load_img();
        start_run();
        wait_done(0, 1'b0);
        read_frame("flat");
        drop_run();

        // Step edge.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img[y][x] = (x >= 2) ? 8'd255 : 8'd0;
        load_img();
        start_run();
        wait_done(0, 1'b0);
        read_frame("step");
        drop_run();

        // Random image with a write attempted during PROC.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img[y][x] = 8'($urandom_range(0, 255));
        load_img();
        start_run();
        repeat (5) @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_x = 3'd2; wr_y = 3'd2; wr_d = ~img[2][2];
        @(negedge clk);
        wr_en = 1'b0;
        wait_done(6, 1'b0);
        check("proc_write_ignored", dut.frame_buf_in.img_buf[2][2], img[2][2]);
        read_frame("rand");
        drop_run();

        // Reset in the middle of PROC, then a clean run.
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                img[y][x] = (x == y) ? 8'(250 + y) : 8'd0;
        load_img();
        start_run();
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_done", done, 0);
        check("midreset_state", dut.state, IDLE);
        @(negedge clk); rst = 1'b0; run = 1'b0;
        @(negedge clk);
        start_run();
        wait_done(0, 1'b1);
        read_frame("after_reset");
        drop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
